l1_cache: RTL

// Direct-mapped, write-back, write-allocate L1 cache. It is the responder for the CPU-side memory port (inst_* or data_*) driven by the pipelined datapath.
// One instance serves instruction fetch and one serves load/store; each converts word requests into 256-bit line transactions on a physical-memory port.
// The CPU holds a request stable until mem_resp; the cache stalls the pipeline by withholding mem_resp.

---
 rtl/l1_cache_pkg.sv | 26 ++
 rtl/l1_cache_array.sv | 62 ++++++
 rtl/l1_cache.sv | 131 +++++++++++++
 3 files changed

// File: rtl/l1_cache_pkg.sv
// Shared types and address helpers for the direct-mapped L1 cache.
package l1_cache_pkg;

  localparam int unsigned S_INDEX_DEFAULT = 3;
  localparam int unsigned LINE_BITS       = 256;
  localparam int unsigned TAG_BITS        = 32 - S_INDEX_DEFAULT - 5;

  typedef logic [LINE_BITS-1:0] cache_line_t;

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StWriteback,
    StFill
  } cache_state_t;

  // Line index, zero-extended; callers keep the low s_index bits.
  function automatic logic [31:0] line_index(input logic [31:0] addr, input int unsigned s_index);
    return (addr >> 5) & ((32'd1 << s_index) - 32'd1);
  endfunction

  function automatic logic [2:0] word_sel(input logic [31:0] addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/l1_cache_array.sv
// Tag, data, valid and dirty storage: synchronous writes, asynchronous reads.
module l1_cache_array
  import l1_cache_pkg::*;
#(
  parameter int unsigned S_INDEX = S_INDEX_DEFAULT,
  parameter int unsigned TAG_W   = TAG_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] index,
  input  logic               load_line,
  input  cache_line_t        line_in,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               load_word,
  input  logic [2:0]         wsel,
  input  logic [3:0]         byte_en,
  input  logic [31:0]        wdata,
  output logic [TAG_W-1:0]   tag_out,
  output cache_line_t        line_out,
  output logic               valid_out,
  output logic               dirty_out
);

  localparam int unsigned Lines = 1 << S_INDEX;

  logic [TAG_W-1:0] tag_q  [Lines];
  cache_line_t      data_q [Lines];
  logic [Lines-1:0] valid_q;
  logic [Lines-1:0] dirty_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (load_line) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (load_word) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Payload needs no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (load_line) begin
      tag_q[index]  <= tag_in;
      data_q[index] <= line_in;
    end else if (load_word) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          data_q[index][{wsel, i[1:0], 3'b000} +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign tag_out   = tag_q[index];
  assign line_out  = data_q[index];
  assign valid_out = valid_q[index];
  assign dirty_out = dirty_q[index];

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back, write-allocate L1 cache: CPU word port to 256-bit line port.
module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int unsigned S_INDEX  = S_INDEX_DEFAULT,
  parameter int unsigned S_OFFSET = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic [31:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output cache_line_t pmem_wdata,
  input  cache_line_t pmem_rdata,
  input  logic        pmem_resp
);

  localparam int unsigned TagW = 32 - S_INDEX - S_OFFSET;

  cache_state_t     state_q, state_d;
  logic [31:0]      idx_full;
  logic [S_INDEX-1:0] idx;
  logic [2:0]       wsel;
  logic [TagW-1:0]  addr_tag;
  logic [TagW-1:0]  tag_out;
  cache_line_t      line_out;
  logic             valid_out;
  logic             dirty_out;
  logic             hit;
  logic             req;
  logic             load_line;
  logic             load_word;
  logic [31:0]      hit_word;
  logic             unused_bits;

  assign idx_full    = line_index(mem_address, S_INDEX);
  assign idx         = idx_full[S_INDEX-1:0];
  assign wsel        = word_sel(mem_address);
  assign addr_tag    = mem_address[31 -: TagW];
  assign unused_bits = ^{mem_address[1:0], idx_full[31:S_INDEX]};

  assign req      = mem_read | mem_write;
  assign hit      = valid_out && (tag_out == addr_tag);
  assign hit_word = line_out[{wsel, 5'b00000} +: 32];

  l1_cache_array #(
    .S_INDEX (S_INDEX),
    .TAG_W   (TagW)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .index     (idx),
    .load_line (load_line),
    .line_in   (pmem_rdata),
    .tag_in    (addr_tag),
    .load_word (load_word),
    .wsel      (wsel),
    .byte_en   (mem_byte_en),
    .wdata     (mem_wdata),
    .tag_out   (tag_out),
    .line_out  (line_out),
    .valid_out (valid_out),
    .dirty_out (dirty_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    load_line    = 1'b0;
    load_word    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) state_d = StCompare;
      end
      StCompare: begin
        if (!req) begin
          state_d = StIdle;
        end else if (hit) begin
          mem_resp  = 1'b1;
          mem_rdata = hit_word;
          // A simultaneous read+write is handled as a write.
          load_word = mem_write;
          state_d   = StIdle;
        end else if (dirty_out) begin
          state_d = StWriteback;
        end else begin
          state_d = StFill;
        end
      end
      StWriteback: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_out, idx, {S_OFFSET{1'b0}}};
        pmem_wdata   = line_out;
        if (pmem_resp) state_d = req ? StFill : StIdle;
      end
      StFill: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          load_line = 1'b1;
          state_d   = req ? StCompare : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  rw_exclusive: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write))
    else $warning("l1_cache: mem_read and mem_write both high, handled as a write");

endmodule
